// File: rtl/exe_pkg.sv
// Shared types and constants for the execute stage.
// Build macro EXE_MUL_EN adds the MUL state for the iterative multiplier.
package exe_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ALU_OP_W_DEF = 14;

  // One-hot ALU opcode bit positions
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLL   = 2;
  localparam int ALU_SLT   = 3;
  localparam int ALU_SLTU  = 4;
  localparam int ALU_XOR   = 5;
  localparam int ALU_SRL   = 6;
  localparam int ALU_SRA   = 7;
  localparam int ALU_OR    = 8;
  localparam int ALU_AND   = 9;
  localparam int ALU_LUI   = 10;  // result = imm
  localparam int ALU_AUIPC = 11;  // result = pc + imm
  localparam int ALU_LINK  = 12;  // result = pc + 4
  localparam int ALU_ADDI  = 13;  // result = src1 + imm

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef EXE_MUL_EN
    ST_MUL  = 2'd2,
`endif
    ST_FULL = 2'd1
  } state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Radix-2 shift-add multiplier, one partial product per step, low XLEN bits kept.
// Present only when EXE_MUL_EN is defined.
`ifdef EXE_MUL_EN
module exe_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] partial_s;

  assign partial_s = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = step_i & (cnt_q == CNT_LAST);
  // The final step's sum is forwarded directly so the product is ready on the done cycle.
  assign product_o = partial_s;

  // Accumulator, shifting operands and step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= partial_s;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= done_o ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule
`endif

// File: rtl/exe_pipe.sv
// Single-entry execute stage: combinational one-hot ALU, valid/ready on both sides.
// Build macro EXE_MUL_EN enables multi-cycle multiplies through exe_mul_iter.
module exe_pipe
  import exe_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALU_OP_W = ALU_OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                left_valid,
  output logic                left_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_src1,
  input  logic [XLEN-1:0]     in_src2,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic                in_is_mul,
  input  logic                in_wreg_en,
  input  logic [4:0]          in_wreg_index,
  output logic                right_valid,
  input  logic                right_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [31:0]         out_inst,
  output logic [XLEN-1:0]     out_result,
  output logic                out_wreg_en,
  output logic [4:0]          out_wreg_index,
  output logic                busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, out_result_q, out_result_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_wreg_en_q, out_wreg_en_d;
  logic [4:0]      out_wreg_index_q, out_wreg_index_d;
  logic            left_ready_s, left_fire_s, right_fire_s, slt_s, sltu_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] sra_s, alu_res_s;

  function automatic logic [XLEN-1:0] sel(input logic en, input logic [XLEN-1:0] v);
    return en ? v : '0;
  endfunction

  assign shamt_s = in_src2[SHW-1:0];
  assign slt_s   = $signed(in_src1) < $signed(in_src2);
  assign sltu_s  = in_src1 < in_src2;
  assign sra_s   = $signed(in_src1) >>> shamt_s;

  // One-hot ALU as an AND-OR mux; unselected lanes contribute zero
  always_comb begin
    alu_res_s = sel(in_alu_op[ALU_ADD],   in_src1 + in_src2)
              | sel(in_alu_op[ALU_SUB],   in_src1 - in_src2)
              | sel(in_alu_op[ALU_SLL],   in_src1 << shamt_s)
              | sel(in_alu_op[ALU_SLT],   {{(XLEN-1){1'b0}}, slt_s})
              | sel(in_alu_op[ALU_SLTU],  {{(XLEN-1){1'b0}}, sltu_s})
              | sel(in_alu_op[ALU_XOR],   in_src1 ^ in_src2)
              | sel(in_alu_op[ALU_SRL],   in_src1 >> shamt_s)
              | sel(in_alu_op[ALU_SRA],   sra_s)
              | sel(in_alu_op[ALU_OR],    in_src1 | in_src2)
              | sel(in_alu_op[ALU_AND],   in_src1 & in_src2)
              | sel(in_alu_op[ALU_LUI],   in_imm)
              | sel(in_alu_op[ALU_AUIPC], in_pc + in_imm)
              | sel(in_alu_op[ALU_LINK],  in_pc + PC_STEP)
              | sel(in_alu_op[ALU_ADDI],  in_src1 + in_imm);
  end

`ifdef EXE_MUL_EN
  logic            mul_start_s, mul_done_s;
  logic [XLEN-1:0] mul_prod_s;

  exe_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (flush),
    .start_i   (mul_start_s),
    .step_i    (state_q == ST_MUL),
    .a_i       (in_src1),
    .b_i       (in_src2),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  assign busy = (state_q == ST_MUL);
`else
  logic unused_is_mul_s;
  assign unused_is_mul_s = in_is_mul;
  assign busy = 1'b0;
`endif

  assign left_ready_s = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_FULL) & right_ready));
  assign left_fire_s  = left_valid & left_ready_s;
  assign right_fire_s = (state_q == ST_FULL) & right_ready;

  // Next-state and output-register load; flush overrides every other event
  always_comb begin
    state_d          = state_q;
    out_pc_d         = out_pc_q;
    out_inst_d       = out_inst_q;
    out_result_d     = out_result_q;
    out_wreg_en_d    = out_wreg_en_q;
    out_wreg_index_d = out_wreg_index_q;
`ifdef EXE_MUL_EN
    mul_start_s      = 1'b0;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FULL: begin
          if (left_fire_s) begin
            out_pc_d         = in_pc;
            out_inst_d       = in_inst;
            out_wreg_en_d    = in_wreg_en;
            out_wreg_index_d = in_wreg_index;
`ifdef EXE_MUL_EN
            if (in_is_mul) begin
              state_d     = ST_MUL;
              mul_start_s = 1'b1;
            end else begin
              state_d      = ST_FULL;
              out_result_d = alu_res_s;
            end
`else
            state_d      = ST_FULL;
            out_result_d = alu_res_s;
`endif
          end else if (right_fire_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
`ifdef EXE_MUL_EN
        ST_MUL: begin
          if (mul_done_s) begin
            state_d      = ST_FULL;
            out_result_d = mul_prod_s;
          end else begin
            state_d = ST_MUL;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      out_pc_q         <= '0;
      out_inst_q       <= '0;
      out_result_q     <= '0;
      out_wreg_en_q    <= 1'b0;
      out_wreg_index_q <= '0;
    end else begin
      state_q          <= state_d;
      out_pc_q         <= out_pc_d;
      out_inst_q       <= out_inst_d;
      out_result_q     <= out_result_d;
      out_wreg_en_q    <= out_wreg_en_d;
      out_wreg_index_q <= out_wreg_index_d;
    end
  end

  assign left_ready     = left_ready_s;
  assign right_valid    = (state_q == ST_FULL);
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_result     = out_result_q;
  assign out_wreg_en    = out_wreg_en_q;
  assign out_wreg_index = out_wreg_index_q;

endmodule

// File: doc/exe_pipe.md
EXE_PIPE -- requirements
Module: exe_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operands, immediate and result.
REQ-002 SHALL have parameter ALU_OP_W, default 14, width of the one-hot ALU opcode.
REQ-003 SHALL have ports `clk in 1` (clock) and `reset in 1` (asynchronous, active-high).
REQ-004 SHALL have port `flush in 1`, which discards the in-flight instruction.
REQ-005 SHALL have port `left_valid in 1`, marking upstream payload valid.
REQ-006 SHALL have port `left_ready out 1`, marking that this stage accepts a payload.
REQ-007 SHALL have input payload ports: `in_pc XLEN`, `in_inst 32`, `in_src1 XLEN`, `in_src2 XLEN`, `in_imm XLEN`, `in_alu_op ALU_OP_W`, `in_is_mul 1`, `in_wreg_en 1`, `in_wreg_index 5`.
REQ-008 SHALL have port `right_valid out 1`, marking output payload valid.
REQ-009 SHALL have port `right_ready in 1`, marking that downstream accepts the payload.
REQ-010 SHALL have output payload ports: `out_pc XLEN`, `out_inst 32`, `out_result XLEN`, `out_wreg_en 1`, `out_wreg_index 5`.
REQ-011 SHALL have port `busy out 1`, high while a multiply iterates.

Function
REQ-012 SHALL define left_fire = left_valid & left_ready and right_fire = right_valid & right_ready.
REQ-013 SHALL have FSM states IDLE (empty), FULL (result held) and MUL (iterating).
REQ-014 SHALL drive left_ready = ~flush & (IDLE | (FULL & right_ready)); left_ready SHALL be 0 in MUL.
REQ-015 On left_fire with in_is_mul=0, SHALL register the payload and the combinational ALU result, go to FULL, and assert right_valid the next cycle (latency 1).
REQ-016 On left_fire with in_is_mul=1, SHALL latch the operands and go to MUL with the iteration counter at 0.
REQ-017 In MUL, SHALL perform one shift-add step per cycle; after XLEN cycles it SHALL load out_result = low XLEN bits of src1*src2 and go to FULL.
REQ-018 In FULL, right_fire without left_fire SHALL go to IDLE; right_fire with left_fire SHALL reload and stay FULL, or go to MUL.
REQ-019 While right_valid=1 and right_ready=0, all out_* SHALL hold stable.
REQ-020 flush SHALL take priority over every event: next state IDLE, right_valid=0, counter cleared, concurrent left payload dropped.
REQ-021 The counter SHALL be $clog2(XLEN) bits wide and SHALL NOT wrap; the terminal count is XLEN-1.
REQ-022 busy SHALL equal (state==MUL).
REQ-023 ALU arithmetic SHALL be modulo 2^XLEN; shifts SHALL use src2[$clog2(XLEN)-1:0].

Reset
REQ-024 On reset: state=IDLE, right_valid=0, busy=0, counter=0, all out_* = 0.
REQ-025 left_ready SHALL be 1 the first cycle after reset deasserts, unless flush is high.
REQ-026 Reset asserted during MUL SHALL abort the multiply with no output produced.

Configuration
REQ-027 Macro EXE_MUL_EN defined: MUL state and exe_mul_iter present, behaviour as REQ-016/017.
REQ-028 Macro EXE_MUL_EN undefined: in_is_mul ignored (the op takes the ALU path, latency 1), MUL state absent, busy tied to 0.

Structure
REQ-029 Package exe_pkg SHALL hold the state enum, the ALU opcode one-hot bit positions, the default XLEN and the default ALU_OP_W.
REQ-030 The iterative multiplier SHALL be sub-module exe_mul_iter (start, operands, done, product); the ALU SHALL be combinational inside exe_pipe.

Verification
REQ-031 Add src1=5, src2=7, right_ready=1 -> right_valid=1 one cycle later, out_result=12.
REQ-032 Back-to-back adds every cycle with right_ready=1 -> one result per cycle, left_ready constantly 1.
REQ-033 Mul 0xFFFFFFFF*3 (XLEN=32) -> busy for 32 cycles, left_ready=0 throughout, then out_result=0xFFFFFFFD.
REQ-034 right_ready=0 for 5 cycles while FULL -> out_* unchanged, left_ready=0; release -> accepts next payload.
REQ-035 flush at cycle 10 of a mul -> IDLE next cycle, right_valid never asserts for that op.
REQ-036 Build without EXE_MUL_EN, in_is_mul=1, add op 2+2 -> out_result=4 after 1 cycle, busy=0.
